// File: rtl/cache_controller_if.sv
// Bundles the CPU, cache-array and main-memory signals of the cache controller.
// The master modport is the controller's view; the slave modport is the view of
// the CPU, the tag/valid/data arrays and main memory together.
interface cache_controller_if #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

    // CPU side
    logic                        cpuReq;
    logic [ADDR_W-1:0]           cpuAddr;
    logic                        cpuReady;
    logic [DATA_W-1:0]           cpuData;
    // tag / valid array
    logic [INDEX_W-1:0]          tagAddr;
    logic                        tagWrEn;
    logic [TAG_W-1:0]            tagIn;
    logic [TAG_W-1:0]            tagOut;
    logic                        validWrEn;
    logic                        validIn;
    logic                        validOut;
    // data array
    logic [INDEX_W+OFFSET_W-1:0] dataAddr;
    logic                        dataWrEn;
    logic [DATA_W-1:0]           dataIn;
    logic [DATA_W-1:0]           dataOut;
    // main memory
    logic                        memReq;
    logic [TAG_W+INDEX_W-1:0]    memAddr;
    logic                        memReady;
    logic [DATA_W-1:0]           memData;
    // statistics
    logic [CNT_W-1:0]            hitCount;
    logic [CNT_W-1:0]            missCount;

    modport master (
        input  cpuReq, cpuAddr, tagOut, validOut, dataOut, memReady, memData,
        output cpuReady, cpuData, tagAddr, tagWrEn, tagIn, validWrEn, validIn,
               dataAddr, dataWrEn, dataIn, memReq, memAddr, hitCount, missCount
    );

    modport slave (
        output cpuReq, cpuAddr, tagOut, validOut, dataOut, memReady, memData,
        input  cpuReady, cpuData, tagAddr, tagWrEn, tagIn, validWrEn, validIn,
               dataAddr, dataWrEn, dataIn, memReq, memAddr, hitCount, missCount
    );
endinterface

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache controller: latches a CPU word address, checks
// tag/valid, refills a 4-word block from main memory on a miss, then re-checks.
// Parameters must match those of the connected cache_controller_if instance.
module cache_controller #(
    parameter int TAG_W    = 3,
    parameter int INDEX_W  = 10,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_controller_if.master    bus
);
    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [OFFSET_W-1:0] LAST_BEAT = {OFFSET_W{1'b1}};

    typedef enum logic [1:0] {IDLE, COMPARE, REFILL, UPDATE} state_e;

    state_e                   state_q, state_d;
    logic [ADDR_W-1:0]        req_addr_q;
    logic [OFFSET_W-1:0]      beat_q;
    logic                     cpu_ready_q;
    logic [DATA_W-1:0]        cpu_data_q;
    logic                     mem_req_q;
    logic [TAG_W+INDEX_W-1:0] mem_addr_q;
    logic [CNT_W-1:0]         hit_cnt_q;
    logic [CNT_W-1:0]         miss_cnt_q;
    logic                     recheck_q;   // the current compare follows a refill

    logic [TAG_W-1:0]         req_tag_s;
    logic [INDEX_W-1:0]       req_index_s;
    logic [OFFSET_W-1:0]      req_offset_s;
    logic                     hit_s;
    logic                     beat_fire_s;

    assign req_tag_s    = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_index_s  = req_addr_q[OFFSET_W +: INDEX_W];
    assign req_offset_s = req_addr_q[OFFSET_W-1:0];
    assign hit_s        = bus.validOut && (bus.tagOut == req_tag_s);
    // memReq is high for the whole of REFILL; the term keeps stray beats out
    assign beat_fire_s  = (state_q == REFILL) && mem_req_q && bus.memReady;

    assign bus.cpuReady  = cpu_ready_q;
    assign bus.cpuData   = cpu_data_q;
    assign bus.memReq    = mem_req_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.hitCount  = hit_cnt_q;
    assign bus.missCount = miss_cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and combinational array control.
    always_comb begin
        state_d       = state_q;
        bus.tagAddr   = req_index_s;
        bus.dataAddr  = {req_index_s, req_offset_s};
        bus.dataWrEn  = 1'b0;
        bus.dataIn    = bus.memData;
        bus.tagWrEn   = 1'b0;
        bus.validWrEn = 1'b0;
        bus.tagIn     = req_tag_s;
        bus.validIn   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpuReq) begin
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                if (hit_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                bus.dataAddr = {req_index_s, beat_q};
                bus.dataWrEn = beat_fire_s;
                if (beat_fire_s && (beat_q == LAST_BEAT)) begin
                    state_d = UPDATE;
                end else begin
                    state_d = REFILL;
                end
            end
            UPDATE: begin
                bus.tagWrEn   = 1'b1;
                bus.validWrEn = 1'b1;
                bus.validIn   = 1'b1;
                state_d       = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, CPU response, refill bookkeeping and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q  <= '0;
            beat_q      <= '0;
            cpu_ready_q <= 1'b0;
            cpu_data_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            recheck_q   <= 1'b0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpuReq) begin
                        req_addr_q <= bus.cpuAddr;
                    end
                end
                COMPARE: begin
                    recheck_q <= 1'b0;
                    if (hit_s) begin
                        cpu_ready_q <= 1'b1;
                        cpu_data_q  <= bus.dataOut;
                        if (!recheck_q && (hit_cnt_q != CNT_MAX)) begin
                            hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (miss_cnt_q != CNT_MAX) begin
                            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                        end
                        mem_addr_q <= {req_tag_s, req_index_s};
                        mem_req_q  <= 1'b1;
                        beat_q     <= '0;
                    end
                end
                REFILL: begin
                    if (beat_fire_s) begin
                        beat_q <= beat_q + OFFSET_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    recheck_q <= 1'b1;
                end
                default: begin
                    recheck_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural tag/valid/data arrays and a main-memory
// responder with a programmable ready pattern; read results go through a queue.
// Counters are narrowed so that saturation is reached within a short run.
module tb_cache_controller;
    localparam int TAG_W    = 3;
    localparam int INDEX_W  = 10;
    localparam int OFFSET_W = 2;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] data;
        int          accept;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    exp_t        sb_q[$];
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [14:0] exp_addr = 15'h0;
    logic [15:0] ready_pat = 16'hFFFF;
    int          pat_idx = 0;
    logic [1:0]  tb_beat = 2'd0;
    logic        fire_q = 1'b0;
    int          wr_count = 0;
    logic        drop_pending = 1'b0;
    logic        prev_ready = 1'b0;
    logic        memreq_seen = 1'b0;
    logic [12:0] mem_addr_seen = 13'h0;

    logic [2:0]  tag_mem [1024];
    logic        valid_mem [1024];
    logic [31:0] data_mem [4096];

    cache_controller_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W),
                          .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cache_controller #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W),
                       .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backing memory contents: block 0x001 holds 0xA0..0xA3.
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        logic [12:0] blk;
        blk = a[14:2] ^ 13'h0001;
        return 32'h0000_00A0 + {30'h0, a[1:0]} + {11'h0, blk, 8'h00};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Arrays: async read, sync write, valid bits cleared by reset.
    assign bus.tagOut   = tag_mem[bus.tagAddr];
    assign bus.validOut = valid_mem[bus.tagAddr];
    assign bus.dataOut  = data_mem[bus.dataAddr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) valid_mem[i] <= 1'b0;
        end else begin
            if (bus.validWrEn) valid_mem[bus.tagAddr] <= bus.validIn;
            if (bus.tagWrEn)   tag_mem[bus.tagAddr]   <= bus.tagIn;
            if (bus.dataWrEn)  data_mem[bus.dataAddr] <= bus.dataIn;
        end
    end

    // Memory responder, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (fire_q) tb_beat = tb_beat + 2'd1;
        if (!bus.memReq) begin
            tb_beat       = 2'd0;
            pat_idx       = 0;
            bus.memReady  = 1'b0;
        end else begin
            bus.memReady = ready_pat[pat_idx];
            if (pat_idx < 15) pat_idx++;
        end
        bus.memData = mem_word({bus.memAddr, tb_beat});
    end

    // Monitor on the falling edge: refill writes, memReq release, read results.
    always @(negedge clk) begin
        if (drop_pending) begin
            check_val("memreq_drop", 32'(bus.memReq), 32'd0);
            drop_pending = 1'b0;
        end
        if (bus.dataWrEn && !rst) begin
            check_val("wr_needs_ready", 32'(bus.memReady), 32'd1);
            check_val("wr_addr", 32'(bus.dataAddr), 32'({exp_addr[11:2], tb_beat}));
            check_val("wr_data", bus.dataIn, mem_word({exp_addr[14:2], tb_beat}));
            wr_count++;
            if (wr_count == 4) drop_pending = 1'b1;
        end
        fire_q = bus.memReady && bus.memReq;
        if (bus.memReq) begin
            memreq_seen   = 1'b1;
            mem_addr_seen = bus.memAddr;
        end
        if (prev_ready) check_val("ready_pulse", 32'(bus.cpuReady), 32'd0);
        prev_ready = bus.cpuReady;
        if (bus.cpuReady) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("rd_data", bus.cpuData, e.data);
                check_val("rd_latency", 32'(cyc + 1 - e.accept), 32'(e.lat));
            end
        end
    end

    task automatic check_reset_vals();
        check_val("rst_cpuReady",  32'(bus.cpuReady),  32'd0);
        check_val("rst_cpuData",   bus.cpuData,        32'd0);
        check_val("rst_memReq",    32'(bus.memReq),    32'd0);
        check_val("rst_memAddr",   32'(bus.memAddr),   32'd0);
        check_val("rst_wren",      32'({bus.tagWrEn, bus.validWrEn, bus.dataWrEn}), 32'd0);
        check_val("rst_hitCount",  32'(bus.hitCount),  32'd0);
        check_val("rst_missCount", 32'(bus.missCount), 32'd0);
    endtask

    task automatic do_read(input logic [14:0] addr, input bit exp_hit,
                           input logic [15:0] pat, input int lat, input bit toggle);
        exp_t e;
        bit   done;
        ready_pat   = pat;
        wr_count    = 0;
        memreq_seen = 1'b0;
        exp_addr    = addr;
        @(posedge clk);
        #2;
        bus.cpuReq  = 1'b1;
        bus.cpuAddr = addr;
        e.data   = mem_word(addr);
        e.accept = cyc + 1;
        e.lat    = lat;
        sb_q.push_back(e);
        if (exp_hit) begin
            if (exp_hits != CNT_MAX) exp_hits++;
        end else begin
            if (exp_misses != CNT_MAX) exp_misses++;
        end
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.cpuReady) begin
                done       = 1'b1;
                bus.cpuReq = 1'b0;
            end else if (toggle && i > 2) begin
                bus.cpuAddr = 15'($urandom);
            end
        end
        if (!done) begin
            check_val("rd_timeout", 32'd0, 32'd1);
            bus.cpuReq = 1'b0;
        end
        #1;
        check_val("hit_count",  32'(bus.hitCount),  32'(exp_hits));
        check_val("miss_count", 32'(bus.missCount), 32'(exp_misses));
        check_val("refill_writes", 32'(wr_count), exp_hit ? 32'd0 : 32'd4);
        check_val("memreq_used", 32'(memreq_seen), exp_hit ? 32'd0 : 32'd1);
    endtask

    initial begin
        bus.cpuReq   = 1'b0;
        bus.cpuAddr  = 15'h0;
        bus.memReady = 1'b0;
        bus.memData  = 32'h0;
        for (int i = 0; i < 1024; i++) tag_mem[i] = 3'h0;
        for (int i = 0; i < 4096; i++) data_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // cold miss, then hit in the same block
        do_read(15'h0005, 1'b0, 16'hFFFF, 8, 1'b0);
        check_val("cold_tag",   32'(tag_mem[1]),   32'd0);
        check_val("cold_valid", 32'(valid_mem[1]), 32'd1);
        do_read(15'h0006, 1'b1, 16'hFFFF, 2, 1'b0);

        // conflict on index 1 and back
        do_read(15'h1005, 1'b0, 16'hFFFF, 8, 1'b0);
        check_val("conf_memAddr", 32'(mem_addr_seen), 32'h401);
        check_val("conf_tag",     32'(tag_mem[1]),    32'd1);
        do_read(15'h0005, 1'b0, 16'hFFFF, 8, 1'b0);

        // stalled refill (1,0,0,1,0,1,1) with cpuAddr toggling while busy
        do_read(15'h3007, 1'b0, 16'hFFE9, 11, 1'b1);
        check_val("stall_tag", 32'(tag_mem[1]), 32'd3);

        // reset during the second refill beat
        ready_pat = 16'hFFFF;
        wr_count  = 0;
        exp_addr  = 15'h2009;
        @(posedge clk);
        #2;
        bus.cpuReq  = 1'b1;
        bus.cpuAddr = 15'h2009;
        for (int i = 0; i < 50 && wr_count < 2; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("rst_beat_reached", 32'(wr_count), 32'd2);
        rst        = 1'b1;
        bus.cpuReq = 1'b0;
        @(negedge clk);
        check_reset_vals();
        check_val("rst_valid_clear", 32'(valid_mem[2]), 32'd0);
        @(posedge clk);
        #2;
        rst        = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;

        // read after reset misses, then run the hit counter into saturation
        do_read(15'h2009, 1'b0, 16'hFFFF, 8, 1'b0);
        for (int k = 0; k < CNT_MAX + 1; k++) begin
            do_read(15'h2008 + 15'(k % 4), 1'b1, 16'hFFFF, 2, 1'b0);
        end
        check_val("hit_saturated", 32'(bus.hitCount), 32'(CNT_MAX));
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
